// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage_pkg : shared constants and FSM encodings for the fetch stage  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package fetch_stage_pkg;

  localparam logic [31:0] c_reset_pc = 32'h0000_0000;
  localparam logic [31:0] c_nop_insn = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifid_reg : pipeline register with load enable and synchronous flush      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ifid_reg #(
  parameter int unsigned     WIDTH     = 65,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Flush wins over enable so a redirect always leaves a bubble behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q <= RESET_VAL;
    end else if (flush) begin
      r_q <= FLUSH_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : PC, next-PC selection, fetch FSM and IF/ID register        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = c_reset_pc,
  parameter logic [31:0] NOP_INSN = c_nop_insn,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             id_jump,
  input  logic [31:0]      id_jump_target,
  input  logic             ex_br_taken,
  input  logic [31:0]      ex_br_target,
  input  logic [31:0]      imem_data,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc4,
  output logic             ifid_valid,
  output logic [31:0]      fetch_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             misalign_err
);

  localparam int unsigned c_ifid_w = 65;
  localparam logic [c_ifid_w-1:0] c_bubble = {NOP_INSN, 32'h0000_0000, 1'b0};

  fetch_state_t        r_state;
  fetch_state_t        w_next_state;
  logic [31:0]         r_pc;
  logic [31:0]         w_pc_next;
  logic [31:0]         w_pc4;
  logic [31:0]         r_fetch_count;
  logic [CNT_W-1:0]    r_flush_count;
  logic                r_misalign_err;

  logic                w_ifid_en;
  logic                w_ifid_flush;
  logic                w_redirect;
  logic [31:0]         w_target;
  logic                w_fetch_inc;
  logic                w_flush_inc;
  logic                w_set_err;
  logic [c_ifid_w-1:0] w_ifid_d;
  logic [c_ifid_w-1:0] w_ifid_q;

  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_next_state = r_state;
    w_pc_next    = r_pc;
    w_ifid_en    = 1'b0;
    w_ifid_flush = 1'b0;
    w_redirect   = 1'b0;
    w_target     = 32'h0000_0000;
    w_fetch_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    w_set_err    = 1'b0;

    case (r_state)
      FS_BOOT: begin
        w_next_state = FS_RUN;
      end
      FS_RUN: begin
        // Branch from EX is older than the jump in ID, so it takes precedence.
        if (ex_br_taken) begin
          w_redirect = 1'b1;
          w_target   = ex_br_target;
        end else if (stall) begin
          w_redirect = 1'b0;
        end else if (id_jump) begin
          w_redirect = 1'b1;
          w_target   = id_jump_target;
        end else begin
          w_pc_next   = w_pc4;
          w_ifid_en   = 1'b1;
          w_fetch_inc = 1'b1;
        end

        if (w_redirect) begin
          w_ifid_flush = 1'b1;
          w_flush_inc  = w_ifid_q[0];
          if (is_misaligned(w_target)) begin
            w_set_err    = 1'b1;
            w_next_state = FS_HALT;
          end else begin
            w_pc_next = w_target;
          end
        end
      end
      FS_HALT: begin
        w_ifid_flush = 1'b1;
      end
      default: begin
        w_next_state = FS_HALT;
        w_ifid_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= FS_BOOT;
      r_pc           <= RESET_PC;
      r_fetch_count  <= 32'h0000_0000;
      r_flush_count  <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_pc_next;
      if (w_fetch_inc) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_flush_inc && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_set_err) begin
        r_misalign_err <= 1'b1;
      end
    end
  end

  assign w_ifid_d = {imem_data, w_pc4, 1'b1};

  ifid_reg #(
    .WIDTH     (c_ifid_w),
    .RESET_VAL (c_bubble),
    .FLUSH_VAL (c_bubble)
  ) u_ifid_reg (
    .clock (clock),
    .reset (reset),
    .en    (w_ifid_en),
    .flush (w_ifid_flush),
    .d     (w_ifid_d),
    .q     (w_ifid_q)
  );

  assign imem_addr    = {2'b00, r_pc[31:2]};
  assign pc           = r_pc;
  assign ifid_instr   = w_ifid_q[64:33];
  assign ifid_pc4     = w_ifid_q[32:1];
  assign ifid_valid   = w_ifid_q[0];
  assign fetch_count  = r_fetch_count;
  assign flush_count  = r_flush_count;
  assign misalign_err = r_misalign_err;

endmodule
`default_nettype wire
